// File: rtl/mc_datapath_param.sv
// mc_datapath_param: parametrised multicycle ARM-subset datapath with memory wait-state handshake
// Ports: clk; reset (async, active-low); Adr/WriteData out and ReadData in (unified memory);
//   MemReady (read data valid); Stall = IRWrite & ~MemReady; Instr and ALUFlags {N,Z,C,V} to controller;
//   PCWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl from controller.
// Optional build macro MC_DATAPATH_DBG_EN adds DbgAddr in / DbgData out, a read-only regfile peek.
module mc_datapath_param #(
    parameter int  WIDTH  = 32,
    parameter int  NREGS  = 16,
    parameter int  PC_IDX = NREGS - 1,
    localparam int RAW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] Adr,
    output logic [WIDTH-1:0] WriteData,
    input  logic [WIDTH-1:0] ReadData,
    input  logic             MemReady,
    output logic             Stall,
    output logic [31:0]      Instr,
    output logic [3:0]       ALUFlags,
    input  logic             PCWrite,
    input  logic             RegWrite,
    input  logic             IRWrite,
    input  logic             AdrSrc,
    input  logic [1:0]       RegSrc,
    input  logic [1:0]       ALUSrcA,
    input  logic [1:0]       ALUSrcB,
    input  logic [1:0]       ResultSrc,
    input  logic [1:0]       ImmSrc,
    input  logic [2:0]       ALUControl
`ifdef MC_DATAPATH_DBG_EN
    ,
    input  logic [RAW-1:0]   DbgAddr,
    output logic [WIDTH-1:0] DbgData
`endif
);
    localparam logic [RAW-1:0] PCI = RAW'(PC_IDX);

    logic [WIDTH-1:0] pc, data, a, wd, alu_out;
    logic [WIDTH-1:0] rf [NREGS];
    logic [RAW-1:0]   ra1, ra2, wa;
    logic [WIDTH-1:0] rd1, rd2, ext_imm, src_a, src_b, b_eff, alu_result, result;
    logic [WIDTH:0]   sum;
    logic             sub, arith;

    assign ra1 = RegSrc[0] ? PCI : Instr[16 +: RAW];
    assign ra2 = RegSrc[1] ? Instr[12 +: RAW] : Instr[0 +: RAW];
    assign wa  = Instr[12 +: RAW];

    // PC index reads the live Result; the controller arranges for that to be PC+8
    assign rd1 = (ra1 == PCI) ? result : rf[ra1];
    assign rd2 = (ra2 == PCI) ? result : rf[ra2];

    assign ext_imm = (ImmSrc == 2'b00) ? WIDTH'(Instr[7:0]) :
                     (ImmSrc == 2'b01) ? WIDTH'(Instr[11:0]) :
                     (ImmSrc == 2'b10) ? {{(WIDTH-26){Instr[23]}}, Instr[23:0], 2'b00} : '0;

    assign src_a = (ALUSrcA == 2'b00) ? a :
                   (ALUSrcA == 2'b01) ? pc :
                   (ALUSrcA == 2'b10) ? alu_out : '0;

    assign src_b = (ALUSrcB == 2'b00) ? wd :
                   (ALUSrcB == 2'b01) ? ext_imm :
                   (ALUSrcB == 2'b10) ? WIDTH'(WIDTH / 8) : '0;

    // Subtract as a + ~b + 1 so the carry-out is the ARM "no borrow" flag
    assign sub   = (ALUControl == 3'b001);
    assign arith = (ALUControl == 3'b000) | sub | (ALUControl == 3'b111);
    assign b_eff = sub ? ~src_b : src_b;
    assign sum   = {1'b0, src_a} + {1'b0, b_eff} + (WIDTH+1)'(sub);

    always_comb begin
        case (ALUControl)
            3'b010:  alu_result = src_a & src_b;
            3'b011:  alu_result = src_a | src_b;
            3'b100:  alu_result = src_a ^ src_b;
            3'b101:  alu_result = src_a & ~src_b;
            3'b110:  alu_result = src_b;
            default: alu_result = sum[WIDTH-1:0];
        endcase
    end

    // Overflow: operands (after inversion for SUB) agree in sign but the sum does not
    assign ALUFlags = {alu_result[WIDTH-1],
                       alu_result == '0,
                       arith & sum[WIDTH],
                       arith & (src_a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] ^ src_a[WIDTH-1])};

    assign result = (ResultSrc == 2'b01) ? data :
                    (ResultSrc == 2'b10) ? alu_result : alu_out;

    assign Adr       = AdrSrc ? result : pc;
    assign WriteData = wd;
    assign Stall     = IRWrite & ~MemReady;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc      <= '0;
            Instr   <= '0;
            data    <= '0;
            a       <= '0;
            wd      <= '0;
            alu_out <= '0;
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else begin
            if (PCWrite) pc <= result;
            if (IRWrite && MemReady) Instr <= ReadData[31:0];
            if (MemReady) data <= ReadData;
            a       <= rd1;
            wd      <= rd2;
            alu_out <= alu_result;
            // PC is only ever loaded through PCWrite
            if (RegWrite && wa != PCI) rf[wa] <= result;
        end
    end

`ifdef MC_DATAPATH_DBG_EN
    assign DbgData = (DbgAddr == PCI) ? pc : rf[DbgAddr];
`endif

endmodule

// File: tb/tb_mc_datapath_param.sv
// tb_mc_datapath_param: directed and random checks of mc_datapath_param against a behavioural model
module tb_mc_datapath_param;
    logic        clk = 0, reset = 0;
    logic [31:0] ReadData = 0;
    logic        MemReady = 0, PCWrite = 0, RegWrite = 0, IRWrite = 0, AdrSrc = 0;
    logic [1:0]  RegSrc = 0, ALUSrcA = 0, ALUSrcB = 0, ResultSrc = 0, ImmSrc = 0;
    logic [2:0]  ALUControl = 0;
    logic [31:0] Adr, WriteData, Instr, adr32, wd32, instr32;
    logic        Stall, stall32;
    logic [3:0]  ALUFlags, flags32;
    int          n_err = 0, n_chk = 0;

    logic [31:0] m_pc, m_instr, m_data, m_a, m_wd, m_aluout;
    logic [31:0] m_rf [16];
    logic [31:0] e_res, e_alu, e_rd1, e_rd2;
    logic [3:0]  e_flags;

`ifdef MC_DATAPATH_DBG_EN
    logic [3:0]  dbg_a16 = 0;
    logic [4:0]  dbg_a32 = 0;
    logic [31:0] dbg_d16, dbg_d32;
`endif

    always #5 clk = ~clk;

    mc_datapath_param u16 (
        .clk(clk), .reset(reset), .Adr(Adr), .WriteData(WriteData), .ReadData(ReadData),
        .MemReady(MemReady), .Stall(Stall), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
        .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl)
`ifdef MC_DATAPATH_DBG_EN
        , .DbgAddr(dbg_a16), .DbgData(dbg_d16)
`endif
    );

    mc_datapath_param #(.NREGS(32)) u32 (
        .clk(clk), .reset(reset), .Adr(adr32), .WriteData(wd32), .ReadData(ReadData),
        .MemReady(MemReady), .Stall(stall32), .Instr(instr32), .ALUFlags(flags32),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
        .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl)
`ifdef MC_DATAPATH_DBG_EN
        , .DbgAddr(dbg_a32), .DbgData(dbg_d32)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_instr = 0; m_data = 0; m_a = 0; m_wd = 0; m_aluout = 0;
        for (int i = 0; i < 16; i++) m_rf[i] = 0;
    endtask

    task automatic idle();
        PCWrite = 0; RegWrite = 0; IRWrite = 0; AdrSrc = 0; MemReady = 0;
        RegSrc = 0; ALUSrcA = 0; ALUSrcB = 0; ResultSrc = 0; ImmSrc = 0; ALUControl = 0;
    endtask

    // Combinational view of the datapath from the model state and current controls
    task automatic eval();
        logic [31:0] x, y, imm;
        logic [3:0]  r1, r2;
        logic        c, v;
        longint      s;
        imm = (ImmSrc == 0) ? {24'b0, m_instr[7:0]} :
              (ImmSrc == 1) ? {20'b0, m_instr[11:0]} :
              (ImmSrc == 2) ? {{6{m_instr[23]}}, m_instr[23:0], 2'b00} : 32'd0;
        x = (ALUSrcA == 0) ? m_a : (ALUSrcA == 1) ? m_pc : (ALUSrcA == 2) ? m_aluout : 32'd0;
        y = (ALUSrcB == 0) ? m_wd : (ALUSrcB == 1) ? imm : (ALUSrcB == 2) ? 32'd4 : 32'd0;
        c = 0; v = 0;
        case (ALUControl)
            3'd1: begin
                e_alu = x - y;
                c = (x >= y);
                s = longint'($signed(x)) - longint'($signed(y));
                v = (s != longint'($signed(e_alu)));
            end
            3'd2: e_alu = x & y;
            3'd3: e_alu = x | y;
            3'd4: e_alu = x ^ y;
            3'd5: e_alu = x & ~y;
            3'd6: e_alu = y;
            default: begin
                e_alu = x + y;
                c = ({1'b0, x} + {1'b0, y}) > 33'h0_FFFF_FFFF;
                s = longint'($signed(x)) + longint'($signed(y));
                v = (s != longint'($signed(e_alu)));
            end
        endcase
        e_flags = {e_alu[31], e_alu == 32'd0, c, v};
        e_res = (ResultSrc == 1) ? m_data : (ResultSrc == 2) ? e_alu : m_aluout;
        r1 = RegSrc[0] ? 4'd15 : m_instr[19:16];
        r2 = RegSrc[1] ? m_instr[15:12] : m_instr[3:0];
        e_rd1 = (r1 == 15) ? e_res : m_rf[r1];
        e_rd2 = (r2 == 15) ? e_res : m_rf[r2];
    endtask

    // One clock with the inputs currently applied: check outputs, then advance the model
    task automatic cyc();
        eval();
        #1;
        chk("adr", Adr, AdrSrc ? e_res : m_pc);
        chk("stall", 32'(Stall), 32'(IRWrite & ~MemReady));
        chk("instr", Instr, m_instr);
        chk("wdata", WriteData, m_wd);
        chk("flags", 32'(ALUFlags), 32'(e_flags));
        @(posedge clk);
        if (RegWrite && m_instr[15:12] != 4'd15) m_rf[m_instr[15:12]] = e_res;
        if (PCWrite) m_pc = e_res;
        if (IRWrite && MemReady) m_instr = ReadData;
        if (MemReady) m_data = ReadData;
        m_a = e_rd1; m_wd = e_rd2; m_aluout = e_alu;
        @(negedge clk);
    endtask

    task automatic fetch(input logic [31:0] w);
        idle(); ReadData = w; IRWrite = 1; MemReady = 1; PCWrite = 1;
        ALUSrcA = 1; ALUSrcB = 2; ResultSrc = 2;
        cyc(); idle();
    endtask

    // R1 <- bv, then A <- av (via PC-index read of Data), WD <- R1, then SUB
    task automatic sub_case(input string tag, input logic [31:0] av, input logic [31:0] bv,
                            input logic [31:0] er, input logic [3:0] ef);
        idle(); ReadData = bv; MemReady = 1; cyc();
        idle(); ResultSrc = 1; RegWrite = 1; ReadData = av; MemReady = 1; cyc();
        idle(); ResultSrc = 1; RegSrc = 2'b11; cyc();
        idle(); ALUControl = 1; ResultSrc = 2; AdrSrc = 1; #1;
        chk({tag, "_res"}, Adr, er);
        chk({tag, "_flags"}, 32'(ALUFlags), 32'(ef));
        cyc(); idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        idle();
        repeat (2) @(negedge clk);
        chk("rst_adr", Adr, 0);
        chk("rst_instr", Instr, 0);
        chk("rst_wdata", WriteData, 0);
        chk("rst_stall", 32'(Stall), 0);
        reset = 1;

        // fetch with two wait states
        ReadData = 32'hE2801005; IRWrite = 1; MemReady = 0;
        cyc();
        chk("t2_stall_w1", 32'(Stall), 1);
        chk("t2_instr_w1", Instr, 0);
        cyc();
        chk("t2_stall_w2", 32'(Stall), 1);
        chk("t2_instr_w2", Instr, 0);
        MemReady = 1; PCWrite = 1; ALUSrcA = 1; ALUSrcB = 2; ResultSrc = 2; #1;
        chk("t2_stall_rdy", 32'(Stall), 0);
        cyc(); idle(); #1;
        chk("t2_instr", Instr, 32'hE2801005);
        chk("t2_pc", Adr, 4);

        // R0 = 3 then ADD R1, R0, #5
        fetch(32'hE3A00003);
        ALUSrcB = 1; ALUControl = 6; ResultSrc = 2; RegWrite = 1; cyc(); idle();
        fetch(32'hE2801005);
        cyc();
        ALUSrcB = 1; ResultSrc = 2; AdrSrc = 1; #1;
        chk("t3_sum", Adr, 8);
        chk("t3_flags", 32'(ALUFlags), 0);
        cyc(); idle();
        RegWrite = 1; cyc(); idle();
        RegSrc = 2'b10; cyc(); idle();
        chk("t3_r1", WriteData, 8);

        sub_case("t4_ovf", 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 4'b1001);
        sub_case("t4_zero", 32'd5, 32'd5, 32'd0, 4'b0110);

        // write to the PC index is dropped; read of the PC index yields Result
        fetch(32'hE3A0F07B);
        ALUSrcB = 1; ALUControl = 6; ResultSrc = 2; RegWrite = 1; #1;
        chk("t5_pc_before", Adr, 16);
        cyc(); idle(); #1;
        chk("t5_pc_after", Adr, 16);
        ALUSrcB = 1; ALUControl = 6; ResultSrc = 2; RegSrc = 2'b10;
        cyc(); idle();
        chk("t5_pcidx_read", WriteData, 123);

        // 32-register instance: R20 = AA written via Instr[16:12], read via Instr[20:16]
        fetch(32'hE3A140AA);
        ALUSrcB = 1; ALUControl = 6; ResultSrc = 2; RegWrite = 1; cyc(); idle();
        fetch(32'hE3B40000);
        cyc();
        ALUSrcB = 3; ResultSrc = 2; AdrSrc = 1; #1;
        chk("t6_r20", adr32, 32'hAA);
        chk("t6_r4", Adr, 32'hAA);
`ifdef MC_DATAPATH_DBG_EN
        dbg_a32 = 20; dbg_a16 = 4; #1;
        chk("t6_dbg32", dbg_d32, 32'hAA);
        chk("t6_dbg16", dbg_d16, 32'hAA);
        dbg_a16 = 15; #1;
        chk("t6_dbg_pc", dbg_d16, 24);
`endif
        cyc(); idle();

        for (int k = 0; k < 400; k++) begin
            {PCWrite, RegWrite, IRWrite, AdrSrc, MemReady} = 5'($urandom);
            RegSrc = 2'($urandom); ALUSrcA = 2'($urandom); ALUSrcB = 2'($urandom);
            ResultSrc = 2'($urandom); ImmSrc = 2'($urandom); ALUControl = 3'($urandom);
            ReadData = $urandom;
            cyc();
        end

        // asynchronous reset in the middle of operation
        idle(); reset = 0; #1;
        chk("t1_adr", Adr, 0);
        chk("t1_instr", Instr, 0);
        chk("t1_wdata", WriteData, 0);
        AdrSrc = 1; #1;
        chk("t1_aluout", Adr, 0);
        chk("t1_adr32", adr32, 0);
        @(negedge clk);
        chk("t1_instr_hold", Instr, 0);
        model_reset();
        idle(); reset = 1;
        for (int k = 0; k < 40; k++) begin
            {PCWrite, RegWrite, IRWrite, AdrSrc, MemReady} = 5'($urandom);
            RegSrc = 2'($urandom); ALUSrcA = 2'($urandom); ALUSrcB = 2'($urandom);
            ResultSrc = 2'($urandom); ImmSrc = 2'($urandom); ALUControl = 3'($urandom);
            ReadData = $urandom;
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
